// File: rtl/relobi_sram_shim.sv
// relobi_sram_shim: TMR-voted, Hsiao-protected request front-end for a single-cycle-latency SRAM.
// addr_i = {ecc, addr}. Define RELOBI_SRAM_SHIM_ERR_RSP_EN to turn uncorrectable addresses into error responses.

package hsiao_ecc_pkg;
  function automatic int unsigned min_ecc(input int unsigned data_width);
    int unsigned k;
    k = 2;
    while ((32'd1 << (k - 1)) < (data_width + k)) k++;
    return k;
  endfunction
endpackage

module relobi_sram_shim #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic [2:0]                                           req_i,
  output logic [2:0]                                           gnt_o,
  input  logic [AddrWidth+hsiao_ecc_pkg::min_ecc(AddrWidth)-1:0] addr_i,
  input  logic                                                 we_i,
  input  logic [DataWidth/8-1:0]                               be_i,
  input  logic [DataWidth-1:0]                                 wdata_i,
  input  logic [IdWidth-1:0]                                   aid_i,
  output logic [2:0]                                           rvalid_o,
  input  logic [2:0]                                           rready_i,
  output logic [DataWidth-1:0]                                 rdata_o,
  output logic [IdWidth-1:0]                                   rid_o,
  output logic                                                 err_o,
  output logic                                                 sram_req_o,
  output logic                                                 sram_we_o,
  output logic [AddrWidth-1:0]                                 sram_addr_o,
  output logic [DataWidth/8-1:0]                               sram_be_o,
  output logic [DataWidth-1:0]                                 sram_wdata_o,
  input  logic [DataWidth-1:0]                                 sram_rdata_i,
  output logic [1:0]                                           fault_o
);

  localparam int unsigned EccWidth = hsiao_ecc_pkg::min_ecc(AddrWidth);
  localparam logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E);
`ifdef RELOBI_SRAM_SHIM_ERR_RSP_EN
  localparam bit ErrRspEn = 1'b1;
`else
  localparam bit ErrRspEn = 1'b0;
`endif

  // Odd-weight columns, lowest weight first, ascending value within a weight.
  function automatic logic [AddrWidth*EccWidth-1:0] gen_hmat();
    logic [AddrWidth*EccWidth-1:0] m;
    logic [EccWidth-1:0]           col;
    int                            idx;
    m   = '0;
    idx = 0;
    for (int w = 3; w <= int'(EccWidth); w += 2) begin
      for (int v = 0; v < (1 << EccWidth); v++) begin
        col = EccWidth'(v);
        if ($countones(col) == w && idx < int'(AddrWidth)) begin
          m[idx*EccWidth +: EccWidth] = col;
          idx++;
        end
      end
    end
    return m;
  endfunction

  localparam logic [AddrWidth*EccWidth-1:0] HMat = gen_hmat();

  logic                 voted_req, voted_rready, vote_mismatch;
  logic [AddrWidth-1:0] addr_raw, addr_fix;
  logic [EccWidth-1:0]  ecc_raw, syndrome;
  logic                 ecc_hit, ecc_sgl, ecc_dbl;
  logic                 rvalid, pop, gnt, acc_err, head_fresh;
  logic [DataWidth-1:0] live_data;

  logic [1:0]           cnt;
  logic                 wr_ptr, rd_ptr, pend_valid, pend_idx;
  logic                 mem_we   [2];
  logic                 mem_err  [2];
  logic [IdWidth-1:0]   mem_id   [2];
  logic [DataWidth-1:0] mem_data [2];

  assign voted_req     = (req_i[0] & req_i[1]) | (req_i[0] & req_i[2]) | (req_i[1] & req_i[2]);
  assign voted_rready  = (rready_i[0] & rready_i[1]) | (rready_i[0] & rready_i[2]) |
                         (rready_i[1] & rready_i[2]);
  assign vote_mismatch = (req_i != {3{req_i[0]}}) | (rready_i != {3{rready_i[0]}});

  assign addr_raw = addr_i[AddrWidth-1:0];
  assign ecc_raw  = addr_i[AddrWidth +: EccWidth];

  always_comb begin
    syndrome = ecc_raw;
    for (int j = 0; j < int'(AddrWidth); j++) begin
      if (addr_raw[j]) syndrome = syndrome ^ HMat[j*EccWidth +: EccWidth];
    end
    addr_fix = addr_raw;
    ecc_hit  = 1'b0;
    for (int j = 0; j < int'(AddrWidth); j++) begin
      if (syndrome == HMat[j*EccWidth +: EccWidth]) begin
        addr_fix[j] = ~addr_raw[j];
        ecc_hit     = 1'b1;
      end
    end
    // A weight-1 syndrome is a flipped check bit: address data is already correct.
    ecc_sgl = ecc_hit | ($countones(syndrome) == 1);
    ecc_dbl = (syndrome != '0) & ~ecc_sgl;
  end

  assign rvalid  = (cnt != 2'd0);
  assign pop     = rvalid & voted_rready;
  assign gnt     = rst_ni & voted_req & ((cnt != 2'd2) | pop);
  assign acc_err = ErrRspEn & ecc_dbl;

  assign gnt_o        = {3{gnt}};
  assign sram_req_o   = gnt & ~acc_err;
  assign sram_we_o    = we_i;
  assign sram_addr_o  = addr_fix;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;
  assign fault_o      = rst_ni ? {voted_req & ecc_dbl, vote_mismatch | (voted_req & ecc_sgl)} : 2'b00;

  // The entry pushed last cycle still waits for its SRAM data; present it straight from the SRAM.
  assign live_data  = mem_err[pend_idx] ? ErrData :
                      mem_we[pend_idx]  ? '0      : sram_rdata_i;
  assign head_fresh = pend_valid & (pend_idx == rd_ptr);

  assign rvalid_o = {3{rvalid}};
  assign rdata_o  = !rvalid ? '0 : (head_fresh ? live_data : mem_data[rd_ptr]);
  assign rid_o    = rvalid ? mem_id[rd_ptr] : '0;
  assign err_o    = rvalid & mem_err[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt        <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_we[i]   <= 1'b0;
        mem_err[i]  <= 1'b0;
        mem_id[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (pend_valid) mem_data[pend_idx] <= live_data;
      pend_valid <= gnt;
      if (gnt) begin
        pend_idx        <= wr_ptr;
        mem_we[wr_ptr]  <= we_i;
        mem_err[wr_ptr] <= acc_err;
        mem_id[wr_ptr]  <= aid_i;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, gnt} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_relobi_sram_shim.sv
// Directed self-checking bench for relobi_sram_shim with a small behavioural SRAM.
// Unwritten SRAM words read as 32'h1000_0000 + word index.
module tb_relobi_sram_shim;

  logic        clk;
  logic        rst_ni;
  logic [2:0]  req_i, gnt_o, rvalid_o, rready_i;
  logic [38:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic [0:0]  aid_i, rid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        sram_req_o, sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o, sram_rdata_i;
  logic [1:0]  fault_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Hand-encoded addresses: {ecc, addr}; columns 0x07,0x0B,0x0D,..,0x16(bit6),0x19(bit7).
  localparam logic [38:0] A00 = {7'h00, 32'h0000_0000};
  localparam logic [38:0] A40 = {7'h16, 32'h0000_0040};
  localparam logic [38:0] A44 = {7'h1B, 32'h0000_0044};
  localparam logic [38:0] A80 = {7'h19, 32'h0000_0080};

  relobi_sram_shim dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .fault_o(fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sram_mem [256];
  logic        sram_wr  [256];
  logic [7:0]  sram_idx;
  assign sram_idx = sram_addr_o[9:2];

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) sram_wr[i] <= 1'b0;
    end else if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) sram_mem[sram_idx][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        sram_wr[sram_idx] <= 1'b1;
      end else begin
        sram_rdata_i <= sram_wr[sram_idx] ? sram_mem[sram_idx] : 32'h1000_0000 + {24'd0, sram_idx};
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [38:0] addr, input logic we,
                       input logic [31:0] wdata, input logic id);
    req_i = req; addr_i = addr; we_i = we; be_i = 4'hF; wdata_i = wdata; aid_i = id;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rready_i = 3'b111;
    drive(3'b111, A40, 1'b0, 32'h0, 1'b0);
    #2;
    n_cmp++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b exp 000", gnt_o); end
    n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 000", rvalid_o); end
    n_cmp++; if (sram_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_sram_req: got %b exp 0", sram_req_o); end
    n_cmp++; if (fault_o !== 2'b00) begin n_fail++; $display("FAIL rst_fault: got %b exp 00", fault_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", rdata_o); end
    next();
    rst_ni = 1'b1;
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    next();
  endtask

  task automatic test_write_read();
    rready_i = 3'b111;
    drive(3'b111, A40, 1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL wr_gnt: got %b exp 111", gnt_o); end
    n_cmp++; if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1) begin n_fail++; $display("FAIL wr_sram: got req %b we %b exp 1 1", sram_req_o, sram_we_o); end
    n_cmp++; if (sram_addr_o !== 32'h40) begin n_fail++; $display("FAIL wr_addr: got %h exp 40", sram_addr_o); end
    next();
    drive(3'b111, A40, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (rvalid_o !== 3'b111) begin n_fail++; $display("FAIL wr_rvalid: got %b exp 111", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'h0 || rid_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got %h/%b/%b exp 0/0/0", rdata_o, rid_o, err_o); end
    n_cmp++; if (gnt_o !== 3'b111 || sram_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_gnt: got %b we %b exp 111 0", gnt_o, sram_we_o); end
    next();
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (rvalid_o !== 3'b111) begin n_fail++; $display("FAIL rd_rvalid: got %b exp 111", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got %h/%b/%b exp deadbeef/1/0", rdata_o, rid_o, err_o); end
    next();
    n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rd_idle: got %b exp 000", rvalid_o); end
  endtask

  task automatic test_back_to_back();
    rready_i = 3'b000;
    drive(3'b111, A40, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL b2b_gnt0: got %b exp 111", gnt_o); end
    next();
    drive(3'b111, A80, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL b2b_gnt1: got %b exp 111", gnt_o); end
    n_cmp++; if (rvalid_o !== 3'b111 || rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_first: got %b %h exp 111 deadbeef", rvalid_o, rdata_o); end
    next();
    drive(3'b111, A00, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL b2b_gnt2: got %b exp 000", gnt_o); end
    next();
    n_cmp++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL b2b_gnt3: got %b exp 000", gnt_o); end
    n_cmp++; if (rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: got %h/%b exp deadbeef/0", rdata_o, rid_o); end
    next();
    rready_i = 3'b111;
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL b2b_regrant: got %b exp 111", gnt_o); end
    n_cmp++; if (rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp0: got %h/%b exp deadbeef/0", rdata_o, rid_o); end
    next();
    drive(3'b111, A44, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL b2b_gnt4: got %b exp 111", gnt_o); end
    n_cmp++; if (rdata_o !== 32'h1000_0020 || rid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp1: got %h/%b exp 10000020/1", rdata_o, rid_o); end
    next();
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (rdata_o !== 32'h1000_0000 || rid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp2: got %h/%b exp 10000000/0", rdata_o, rid_o); end
    next();
    n_cmp++; if (rdata_o !== 32'h1000_0011 || rid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp3: got %h/%b exp 10000011/1", rdata_o, rid_o); end
    next();
    n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL b2b_drain: got %b exp 000", rvalid_o); end
  endtask

  task automatic test_vote();
    rready_i = 3'b111;
    drive(3'b011, A40, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL vote_gnt: got %b exp 111", gnt_o); end
    n_cmp++; if (fault_o !== 2'b01) begin n_fail++; $display("FAIL vote_fault: got %b exp 01", fault_o); end
    next();
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (fault_o !== 2'b00) begin n_fail++; $display("FAIL vote_fault_clr: got %b exp 00", fault_o); end
    n_cmp++; if (rvalid_o !== 3'b111 || rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b1) begin n_fail++; $display("FAIL vote_rsp: got %b %h %b exp 111 deadbeef 1", rvalid_o, rdata_o, rid_o); end
    next();
  endtask

  task automatic test_ecc();
    rready_i = 3'b111;
    drive(3'b111, A40 ^ 39'h1, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (sram_addr_o !== 32'h40 || sram_req_o !== 1'b1) begin n_fail++; $display("FAIL ecc_sgl_addr: got %h req %b exp 40 1", sram_addr_o, sram_req_o); end
    n_cmp++; if (fault_o !== 2'b01) begin n_fail++; $display("FAIL ecc_sgl_fault: got %b exp 01", fault_o); end
    next();
    drive(3'b111, A40 ^ 39'h3, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (fault_o !== 2'b10) begin n_fail++; $display("FAIL ecc_dbl_fault: got %b exp 10", fault_o); end
    n_cmp++; if (rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b0) begin n_fail++; $display("FAIL ecc_sgl_rsp: got %h/%b exp deadbeef/0", rdata_o, rid_o); end
`ifdef RELOBI_SRAM_SHIM_ERR_RSP_EN
    n_cmp++; if (sram_req_o !== 1'b0 || gnt_o !== 3'b111) begin n_fail++; $display("FAIL ecc_dbl_req: got req %b gnt %b exp 0 111", sram_req_o, gnt_o); end
`else
    n_cmp++; if (sram_req_o !== 1'b1 || sram_addr_o !== 32'h43) begin n_fail++; $display("FAIL ecc_dbl_req: got req %b addr %h exp 1 43", sram_req_o, sram_addr_o); end
`endif
    next();
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    #1;
`ifdef RELOBI_SRAM_SHIM_ERR_RSP_EN
    n_cmp++; if (err_o !== 1'b1 || rdata_o !== 32'hBADC_AB1E || rid_o !== 1'b1) begin n_fail++; $display("FAIL ecc_dbl_rsp: got %b/%h/%b exp 1/badcab1e/1", err_o, rdata_o, rid_o); end
`else
    n_cmp++; if (err_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF || rid_o !== 1'b1) begin n_fail++; $display("FAIL ecc_dbl_rsp: got %b/%h/%b exp 0/deadbeef/1", err_o, rdata_o, rid_o); end
`endif
    next();
  endtask

  task automatic test_reset_mid();
    rready_i = 3'b000;
    drive(3'b111, A40, 1'b0, 32'h0, 1'b0);
    next();
    drive(3'b111, A80, 1'b0, 32'h0, 1'b1);
    next();
    #1;
    n_cmp++; if (gnt_o !== 3'b000 || rvalid_o !== 3'b111) begin n_fail++; $display("FAIL mid_full: got gnt %b rvalid %b exp 000 111", gnt_o, rvalid_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (gnt_o !== 3'b000 || rvalid_o !== 3'b000 || sram_req_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs: got %b %b %b exp 000 000 0", gnt_o, rvalid_o, sram_req_o); end
    n_cmp++; if (rdata_o !== 32'h0 || rid_o !== 1'b0 || err_o !== 1'b0 || fault_o !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rsp: got %h %b %b %b exp 0 0 0 00", rdata_o, rid_o, err_o, fault_o); end
    next();
    rst_ni = 1'b1;
    rready_i = 3'b111;
    drive(3'b111, A80, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (gnt_o !== 3'b111) begin n_fail++; $display("FAIL mid_regrant: got %b exp 111", gnt_o); end
    next();
    drive(3'b000, A00, 1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (rvalid_o !== 3'b111 || rdata_o !== 32'h1000_0020 || rid_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rsp: got %b %h %b %b exp 111 10000020 1 0", rvalid_o, rdata_o, rid_o, err_o); end
    next();
    n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL mid_idle: got %b exp 000", rvalid_o); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_vote();
    test_ecc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/relobi_sram_shim.md
RELOBI_SRAM_SHIM -- requirements
Module: relobi_sram_shim

Interface
REQ-001 SHALL have parameter AddrWidth, 32, byte address width before ECC.
REQ-002 SHALL have parameter DataWidth, 32, data width (multiple of 8).
REQ-003 SHALL have parameter IdWidth, 1, transaction ID width.
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  in  3  TMR copies of A-channel request.
REQ-007 SHALL have port gnt_o  out  3  TMR copies of grant, all bits identical.
REQ-008 SHALL have port addr_i  in  AddrWidth+hsiao_ecc_pkg::min_ecc(AddrWidth)  Hsiao-encoded address.
REQ-009 SHALL have port we_i  in  1  write enable.
REQ-010 SHALL have port be_i  in  DataWidth/8  byte enables.
REQ-011 SHALL have port wdata_i  in  DataWidth  write data.
REQ-012 SHALL have port aid_i  in  IdWidth  request ID.
REQ-013 SHALL have port rvalid_o  out  3  TMR copies of response valid, all bits identical.
REQ-014 SHALL have port rready_i  in  3  TMR copies of response ready.
REQ-015 SHALL have port rdata_o  out  DataWidth  read data (0 for writes).
REQ-016 SHALL have port rid_o  out  IdWidth  echoed aid.
REQ-017 SHALL have port err_o  out  1  response error flag.
REQ-018 SHALL have port sram_req_o  out  1  SRAM access strobe.
REQ-019 SHALL have port sram_we_o  out  1  SRAM write enable.
REQ-020 SHALL have port sram_addr_o  out  AddrWidth  decoded/corrected address.
REQ-021 SHALL have port sram_be_o  out  DataWidth/8  SRAM byte enables.
REQ-022 SHALL have port sram_wdata_o  out  DataWidth  SRAM write data.
REQ-023 SHALL have port sram_rdata_i  in  DataWidth  SRAM read data, valid exactly one cycle after sram_req_o.
REQ-024 SHALL have port fault_o  out  2  [0] correctable fault, [1] uncorrectable fault, single-cycle pulses.

Function
REQ-025 SHALL majority-vote req_i and rready_i (2-of-3); any copy disagreement SHALL pulse fault_o[0] that cycle.
REQ-026 SHALL Hsiao-decode addr_i every cycle req is voted high; single-bit error corrected and fault_o[0] pulsed; double-bit error pulses fault_o[1].
REQ-027 SHALL track outstanding count C (0..2) = accepted but not yet R-handshaked; gnt = voted_req & (C<2), combinational from inputs and C.
REQ-028 SHALL, on A handshake (voted_req & gnt) in cycle N, drive sram_req_o=1 with sram_we_o/addr/be/wdata in the same cycle N, else sram_req_o=0.
REQ-029 SHALL capture sram_rdata_i (reads) or 0 (writes), aid and error into a 2-entry response FIFO in cycle N+1.
REQ-030 SHALL drive rvalid = FIFO not empty, rdata/rid/err from FIFO head; first-word latency exactly one cycle (rvalid in N+1).
REQ-031 SHALL hold rvalid/rdata/rid/err stable while rvalid=1 and voted rready=0; pop on rvalid & voted rready.
REQ-032 SHALL update C: +1 on A handshake, -1 on R handshake, unchanged when both coincide; sustain one transaction per cycle with rready held high.
REQ-033 SHALL never overflow the FIFO: C=2 blocks gnt; grant SHALL re-assert in the cycle C drops below 2 (same-cycle pop allows grant).
REQ-034 SHALL keep responses in request order; IDs are echoed, never reordered.

Reset
REQ-035 SHALL on rst_ni=0 asynchronously clear C and FIFO; gnt_o=0, rvalid_o=0, rdata_o=0, rid_o=0, err_o=0, sram_req_o=0, fault_o=0.
REQ-036 SHALL discard in-flight SRAM reads on reset mid-operation; first grant possible in first cycle after rst_ni rises.

Configuration
REQ-037 SHALL with RELOBI_SRAM_SHIM_ERR_RSP_EN defined: on uncorrectable address, suppress sram_req_o, still grant, return err_o=1, rdata_o=32'hBADCAB1E (truncated/zero-extended to DataWidth).
REQ-038 SHALL without RELOBI_SRAM_SHIM_ERR_RSP_EN: perform the access with the raw data bits of addr_i, err_o=0, fault_o[1] still pulsed.

Verification
REQ-039 SHALL test: write addr 0x40 data 0xDEADBEEF be 0xF, then read 0x40, rready=1 -> rvalid one cycle after each grant, read rdata=0xDEADBEEF, err=0.
REQ-040 SHALL test: 4 back-to-back reads, rready=0 -> gnt high for first 2 only, then low; rready raised -> responses in order, rid matching aid 0,1,0,1.
REQ-041 SHALL test: req_i=3'b011 -> treated as request, fault_o[0]=1 one cycle, normal response.
REQ-042 SHALL test: single flipped bit in addr_i of 0x40 -> sram_addr_o=0x40, fault_o[0]=1; double flipped bit with macro -> sram_req_o=0, err=1, rdata=0xBADCAB1E, fault_o[1]=1.
REQ-043 SHALL test: rst_ni low while C=2 -> all outputs 0 immediately; after release, new read completes normally.
